// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port instruction memory between CPU fetch and a program loader.
// Define IMEM_ARB_BOOT_EN to build the BOOT phase that holds the CPU until ld_done.
module imem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LD_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    output logic              cpu_hold,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              ld_done,
    output logic [15:0]       boot_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic [3:0] streak;
    logic       boot;
    logic       ld_wins;
`ifdef IMEM_ARB_BOOT_EN
    typedef enum logic {BOOT, RUN} state_t;
    state_t      state;
    logic [15:0] words;
    assign boot       = state == BOOT;
    assign boot_words = words;
    always_ff @(posedge clk)
        if (!rst) begin
            state <= BOOT;
            words <= '0;
        end else begin
            if (boot && ld_gnt && words != 16'hFFFF) words <= words + 16'd1;
            if (boot && ld_done) state <= RUN;
        end
`else
    logic unused_ld_done;
    assign unused_ld_done = ld_done;
    assign boot           = 1'b0;
    assign boot_words     = '0;
`endif
    // The loader only yields once it has starved a waiting fetch for LD_BURST_MAX cycles.
    assign ld_wins     = !(fetch_req && streak == 4'(LD_BURST_MAX));
    assign ld_gnt      = rst && ld_req && (boot || ld_wins);
    assign fetch_gnt   = rst && !boot && fetch_req && !ld_gnt;
    assign cpu_hold    = !rst || boot || (fetch_req && !fetch_gnt);
    assign mem_addr    = fetch_gnt ? fetch_addr : ld_gnt ? ld_addr : '0;
    assign mem_wdata   = ld_wdata;
    assign mem_we      = ld_gnt;
    assign mem_rd_en   = fetch_gnt;
    assign fetch_instr = fetch_valid ? mem_rdata : '0;
    always_ff @(posedge clk)
        if (!rst) begin
            streak      <= '0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= fetch_gnt;
            streak      <= (boot || fetch_gnt || !fetch_req) ? '0 : ld_gnt ? streak + 4'd1 : streak;
        end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter with a rule-level reference model.
module tb_imem_arbiter;
`ifdef IMEM_ARB_BOOT_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif
    localparam int LD_BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0, ld_req = 1'b0, ld_done = 1'b0;
    logic [31:0] fetch_addr = '0, ld_addr = '0, ld_wdata = '0;
    logic        fetch_gnt, fetch_valid, cpu_hold, ld_gnt, mem_we, mem_rd_en;
    logic [31:0] fetch_instr, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] boot_words;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .LD_BURST_MAX(LD_BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .cpu_hold(cpu_hold),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .ld_done(ld_done), .boot_words(boot_words),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical single-port memory the DUT talks to.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr[7:0]];
    end

    // Reference model: image contents, phase, starvation count, boot word count.
    logic [31:0] img [0:255];
    bit          m_boot;
    int          m_streak, m_bw;
    bit          exp_fv, started;
    logic [31:0] exp_q [$];
    int          n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_fv});
        if (fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_fetch", 32'd1, 32'd0);
            else chk("fetch_instr", fetch_instr, exp_q.pop_front());
        end else chk("instr_idle", fetch_instr, 32'd0);
    end

    task automatic cyc(input bit r, input bit fr, input bit lr, input bit ld,
                       input logic [7:0] fa, input logic [7:0] la, input logic [31:0] lw);
        bit fg, lg, hold;
        logic [31:0] addr;
        rst = r; fetch_req = fr; ld_req = lr; ld_done = ld;
        fetch_addr = {24'b0, fa}; ld_addr = {24'b0, la}; ld_wdata = lw;
        if (!r) begin
            fg = 0; lg = 0;
        end else if (m_boot) begin
            fg = 0; lg = lr;
        end else begin
            lg = lr && !(fr && m_streak == LD_BURST_MAX);
            fg = fr && !lg;
        end
        hold = !r || m_boot || (fr && !fg);
        addr = fg ? {24'b0, fa} : lg ? {24'b0, la} : 32'd0;
        #2;
        chk("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, fg});
        chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, lg});
        chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, hold});
        chk("mem_we", {31'b0, mem_we}, {31'b0, lg});
        chk("mem_rd_en", {31'b0, mem_rd_en}, {31'b0, fg});
        chk("mem_addr", mem_addr, addr);
        if (lg) chk("mem_wdata", mem_wdata, lw);
        chk("boot_words", {16'b0, boot_words}, m_bw);
        if (fg) exp_q.push_back(img[fa]);
        if (lg) img[la] = lw;
        if (!r) begin
            m_boot = BOOT_EN; m_streak = 0; m_bw = 0;
        end else if (m_boot) begin
            if (lg && m_bw < 65535) m_bw++;
            if (ld) m_boot = 0;
            m_streak = 0;
        end else m_streak = (fg || !fr) ? 0 : lg ? m_streak + 1 : m_streak;
        @(posedge clk);
        #1;
        exp_fv = fg;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin ram[i] = '0; img[i] = '0; end
        m_boot = BOOT_EN; m_streak = 0; m_bw = 0; exp_fv = 0; started = 0;
        @(posedge clk); #1;
        cyc(0, 1, 0, 0, 8'd0, 8'd0, 32'd0);
        started = 1;
        cyc(0, 1, 1, 0, 8'd0, 8'd5, 32'h55);
        // Released with only a fetch pending: held in BOOT, granted immediately otherwise.
        repeat (4) cyc(1, 1, 0, 0, 8'd0, 8'd0, 32'd0);
        // Boot image load, then end of boot.
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 8'(i), 8'(i), 32'hA0 + 32'(i));
        cyc(1, 0, 0, 1, 8'd0, 8'd0, 32'd0);
        cyc(1, 1, 0, 0, 8'd0, 8'd0, 32'd0);
        cyc(1, 1, 0, 0, 8'd1, 8'd0, 32'd0);
        cyc(1, 0, 0, 0, 8'd0, 8'd0, 32'd0);
        // Sustained contention: loader bursts of LD_BURST_MAX broken by one fetch.
        for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 8'(i % 3), 8'(100 + i), 32'hB000 + 32'(i));
        cyc(1, 0, 0, 0, 8'd0, 8'd0, 32'd0);
        // Loader write coinciding with ld_done, then a stray ld_done in RUN.
        cyc(0, 0, 0, 0, 8'd0, 8'd0, 32'd0);
        cyc(1, 0, 1, 1, 8'd0, 8'd7, 32'hC7);
        cyc(1, 0, 0, 1, 8'd0, 8'd0, 32'd0);
        cyc(1, 1, 0, 0, 8'd7, 8'd0, 32'd0);
        // Fetch granted, then reset: in-flight read must not survive the reset edge.
        cyc(1, 1, 0, 0, 8'd2, 8'd0, 32'd0);
        cyc(0, 1, 1, 0, 8'd2, 8'd9, 32'hDD);
        cyc(1, 1, 0, 1, 8'd0, 8'd0, 32'd0);
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 15)),
                8'($urandom_range(0, 15)), $urandom);
        cyc(1, 0, 0, 0, 8'd0, 8'd0, 32'd0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Arbiter and sequencer for the single-port instruction memory behind the fetch stage. It shares the memory between CPU instruction fetch and a program loader (boot/debug write port). It holds the CPU in a boot phase until a program image is loaded. It feeds a hold signal into the fetch stage's hazard input so the PC freezes whenever a fetch is not granted.

## Interface
- ADDR_W, 32, address width for both requesters and the memory
- DATA_W, 32, instruction/data word width
- LD_BURST_MAX, 4, maximum consecutive loader grants while a fetch is pending (1..15)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- fetch_req  in  1  fetch stage requests a read at fetch_addr
- fetch_addr  in  ADDR_W  PC to read
- fetch_gnt  out  1  fetch read issued to memory this cycle
- fetch_valid  out  1  fetch_instr is valid (one cycle after fetch_gnt)
- fetch_instr  out  DATA_W  returned instruction; 0 when fetch_valid=0
- cpu_hold  out  1  freeze PC; ORed into fetch-stage hazard
- ld_req  in  1  loader requests a write
- ld_addr  in  ADDR_W  write address
- ld_wdata  in  DATA_W  write data
- ld_gnt  out  1  loader write issued this cycle
- ld_done  in  1  single-cycle pulse: image complete, end boot
- boot_words  out  16  words written during BOOT, saturating at 16'hFFFF
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd_en  out  1  memory read enable
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_rd_en

## Operation
- States: BOOT, RUN. Reset enters BOOT. See Configuration for the reset state when boot is compiled out.
- BOOT behaviour:
  - fetch_gnt=0 and cpu_hold=1.
  - ld_req → ld_gnt=1 the same cycle.
  - boot_words increments on each ld_gnt.
  - ld_done → RUN at the next edge.
  - ld_req and ld_done together: the write is still performed and counted.
- RUN, only fetch_req: fetch_gnt=1.
- RUN, only ld_req: ld_gnt=1.
- RUN, both requesting: the loader wins unless streak==LD_BURST_MAX, in which case the fetch wins.
- streak (4-bit) behaviour:
  - +1 on a loader grant while fetch_req=1.
  - Cleared on any fetch grant, or on any cycle with fetch_req=0.
- ld_done in RUN is ignored. boot_words holds its value in RUN.
- cpu_hold = BOOT | (fetch_req & !fetch_gnt).
- Memory mux:
  - The granted requester drives mem_addr.
  - mem_we = ld_gnt; mem_wdata = ld_wdata.
  - mem_rd_en = fetch_gnt.
  - With no grant: mem_addr=0, mem_we=0, mem_rd_en=0.
- No write-to-read forwarding. Ordering is guaranteed by serialisation: a write at cycle t is visible to a fetch granted at t+1 or later.

## Timing
- Grants and memory-side outputs are combinational from state, streak and requests in the same cycle.
- fetch_valid is registered: fetch_valid(t+1)=fetch_gnt(t).
- fetch_instr = mem_rdata when fetch_valid, else 0. Read latency is 1 cycle.
- Back-to-back fetch grants deliver one instruction per cycle.
- During reset (rst=0 at the edge), the following take effect at the next edge:
  - State to BOOT; streak=0; boot_words=0; fetch_valid=0.
- While rst=0:
  - fetch_gnt=0, ld_gnt=0, mem_we=0, mem_rd_en=0, cpu_hold=1.
- Reset mid-operation: an in-flight read is discarded; fetch_valid is 0 the cycle after reset is sampled.
- A loader write in progress under reset is not issued.

## Configuration
- IMEM_ARB_BOOT_EN defined:
  - Reset enters BOOT.
  - The CPU is held until ld_done.
  - boot_words is active.
- IMEM_ARB_BOOT_EN undefined:
  - Reset enters RUN directly; the BOOT state is not built.
  - ld_done is ignored.
  - boot_words is tied to 0.
  - cpu_hold = fetch_req & !fetch_gnt; during reset cpu_hold=1.

## Test plan
- Reset, then rst=1 with fetch_req=1 and no loader, macro on → cpu_hold=1 and fetch_gnt=0 indefinitely; fetch_valid=0; boot_words=0.
- BOOT: 3 writes, addrs 0,1,2 with data 0xA0,0xA1,0xA2 on consecutive cycles; then ld_done → boot_words=3 and state RUN.
  - Fetch of addr 0 then 1 → fetch_valid on the next two cycles, fetch_instr=0xA0 then 0xA1.
- RUN, fetch_req and ld_req held high for 12 cycles, LD_BURST_MAX=4 → grant pattern L,L,L,L,F repeating (L,L,L,L,F,L,L,L,L,F,L,L).
  - cpu_hold=1 exactly on the L cycles.
- ld_req and ld_done asserted together in BOOT → write issued (mem_we=1), boot_words+1, RUN next cycle.
  - A later ld_done in RUN causes no state change.
- Fetch granted at cycle t, rst=0 sampled at t's edge → fetch_valid=0 at t+1, state BOOT, streak and boot_words cleared.
- Macro off: first cycle after reset with fetch_req=1 → fetch_gnt=1, mem_rd_en=1, fetch_valid next cycle; boot_words stays 0.
